// File: rtl/systemfile_cpu_cpu_debug_mem_arbiter_pkg.sv
// Shared types and default widths for the debug RAM arbiter.
package systemfile_cpu_cpu_debug_mem_arbiter_pkg;

    localparam int unsigned ADDR_W_DEF = 8;
    localparam int unsigned DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RDATA  = 2'd2
    } state_e;

    typedef enum logic {
        GNT_AV   = 1'b0,
        GNT_JTAG = 1'b1
    } grant_e;

endpackage

// File: rtl/systemfile_cpu_cpu_debug_mem_arbiter_rr_grant.sv
// Two-way round-robin between Avalon and JTAG; a tie goes to whoever was not granted last.
module systemfile_cpu_cpu_debug_mem_arbiter_rr_grant
    import systemfile_cpu_cpu_debug_mem_arbiter_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic req_av,
    input  logic req_jtag,
    input  logic take,
    output logic gnt_valid_c,
    output logic gnt_jtag_c
);

    grant_e last_grant_q;
    grant_e last_grant_d;
    grant_e gnt;

    // Pick the winner and remember it when the grant is actually taken.
    always_comb begin
        gnt          = GNT_AV;
        last_grant_d = last_grant_q;
        if (req_av && req_jtag) begin
            gnt = (last_grant_q == GNT_AV) ? GNT_JTAG : GNT_AV;
        end else if (req_jtag) begin
            gnt = GNT_JTAG;
        end
        if (take && (req_av || req_jtag)) begin
            last_grant_d = gnt;
        end
    end

    assign gnt_valid_c = req_av | req_jtag;
    assign gnt_jtag_c  = (gnt == GNT_JTAG);

    // Reset to AV so JTAG wins the first tie.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_q <= GNT_AV;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/systemfile_cpu_cpu_debug_mem_arbiter.sv
// Shares the single-port OCI debug RAM between the JTAG debug path and the Avalon debug slave.
module systemfile_cpu_cpu_debug_mem_arbiter
    import systemfile_cpu_cpu_debug_mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_W-1:0]     av_address,
    input  logic                  av_read,
    input  logic                  av_write,
    input  logic [DATA_W-1:0]     av_writedata,
    input  logic [DATA_W/8-1:0]   av_byteenable,
    output logic                  av_waitrequest,
    output logic [DATA_W-1:0]     av_readdata,
    input  logic                  jtag_addr_load,
    input  logic [ADDR_W-1:0]     jtag_addr_in,
    input  logic                  jtag_req,
    input  logic                  jtag_wr,
    input  logic [DATA_W-1:0]     jtag_wdata,
    input  logic                  jtag_clr_err,
    output logic [DATA_W-1:0]     MonDReg,
    output logic                  monitor_ready,
    output logic                  jtag_overrun,
    output logic                  ram_en,
    output logic                  ram_we,
    output logic [ADDR_W-1:0]     ram_addr,
    output logic [DATA_W-1:0]     ram_wdata,
    output logic [DATA_W/8-1:0]   ram_be,
    input  logic [DATA_W-1:0]     ram_rdata
);

    localparam int unsigned BE_W = DATA_W / 8;

    state_e              state_q, state_d;
    logic                jtag_pend_q, jtag_pend_d;
    logic                jtag_wr_q, jtag_wr_d;
    logic [DATA_W-1:0]   jtag_wdata_q, jtag_wdata_d;
    logic [ADDR_W-1:0]   jtag_addr_q, jtag_addr_d;
    logic [DATA_W-1:0]   mon_q, mon_d;
    logic                mready_q, mready_d;
    logic                overrun_q, overrun_d;
    logic                av_wait_q, av_wait_d;
    logic                ram_en_q, ram_en_d;
    logic                ram_we_q, ram_we_d;
    logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0]   ram_wdata_q, ram_wdata_d;
    logic [BE_W-1:0]     ram_be_q, ram_be_d;
    grant_e              gnt_src_q, gnt_src_d;

    logic                av_req;
    logic                gnt_valid_c;
    logic                gnt_jtag_c;
    logic                take;
    logic                jtag_done;

    assign av_req = av_read | av_write;
    assign take   = (state_q == ST_IDLE);

    systemfile_cpu_cpu_debug_mem_arbiter_rr_grant u_rr_grant (
        .clk         (clk),
        .reset       (reset),
        .req_av      (av_req),
        .req_jtag    (jtag_pend_q),
        .take        (take),
        .gnt_valid_c (gnt_valid_c),
        .gnt_jtag_c  (gnt_jtag_c)
    );

    // Next-state, JTAG bookkeeping and the registered RAM/Avalon strobes.
    always_comb begin
        state_d      = state_q;
        jtag_pend_d  = jtag_pend_q;
        jtag_wr_d    = jtag_wr_q;
        jtag_wdata_d = jtag_wdata_q;
        jtag_addr_d  = jtag_addr_q;
        mon_d        = mon_q;
        overrun_d    = overrun_q;
        av_wait_d    = 1'b1;
        ram_en_d     = 1'b0;
        ram_we_d     = 1'b0;
        ram_addr_d   = ram_addr_q;
        ram_wdata_d  = ram_wdata_q;
        ram_be_d     = ram_be_q;
        gnt_src_d    = gnt_src_q;
        jtag_done    = 1'b0;

        // A new overrun beats a simultaneous clear.
        if (jtag_clr_err) begin
            overrun_d = 1'b0;
        end
        if (jtag_req) begin
            if (jtag_pend_q) begin
                overrun_d = 1'b1;
            end else begin
                jtag_pend_d  = 1'b1;
                jtag_wr_d    = jtag_wr;
                jtag_wdata_d = jtag_wdata;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (gnt_valid_c) begin
                    state_d  = ST_ACCESS;
                    ram_en_d = 1'b1;
                    if (gnt_jtag_c) begin
                        gnt_src_d   = GNT_JTAG;
                        ram_we_d    = jtag_wr_q;
                        ram_addr_d  = jtag_addr_q;
                        ram_wdata_d = jtag_wdata_q;
                        ram_be_d    = '1;
                    end else begin
                        gnt_src_d   = GNT_AV;
                        ram_we_d    = av_write;
                        ram_addr_d  = av_address;
                        ram_wdata_d = av_writedata;
                        ram_be_d    = av_byteenable;
                        av_wait_d   = ~av_write;
                    end
                end
            end
            ST_ACCESS: begin
                if (ram_we_q) begin
                    state_d   = ST_IDLE;
                    jtag_done = (gnt_src_q == GNT_JTAG);
                end else begin
                    state_d   = ST_RDATA;
                    av_wait_d = (gnt_src_q == GNT_JTAG);
                end
            end
            ST_RDATA: begin
                state_d = ST_IDLE;
                if (gnt_src_q == GNT_JTAG) begin
                    mon_d     = ram_rdata;
                    jtag_done = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (jtag_done) begin
            jtag_pend_d = 1'b0;
            jtag_addr_d = jtag_addr_q + ADDR_W'(1);
        end
        // An explicit address load overrides the post-access increment.
        if (jtag_addr_load) begin
            jtag_addr_d = jtag_addr_in;
        end

        mready_d = ~jtag_pend_d;
    end

    // State and datapath registers; reset aborts any access and drops pending JTAG work.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            jtag_pend_q  <= 1'b0;
            jtag_wr_q    <= 1'b0;
            jtag_wdata_q <= '0;
            jtag_addr_q  <= '0;
            mon_q        <= '0;
            mready_q     <= 1'b1;
            overrun_q    <= 1'b0;
            av_wait_q    <= 1'b1;
            ram_en_q     <= 1'b0;
            ram_we_q     <= 1'b0;
            ram_addr_q   <= '0;
            ram_wdata_q  <= '0;
            ram_be_q     <= '0;
            gnt_src_q    <= GNT_AV;
        end else begin
            state_q      <= state_d;
            jtag_pend_q  <= jtag_pend_d;
            jtag_wr_q    <= jtag_wr_d;
            jtag_wdata_q <= jtag_wdata_d;
            jtag_addr_q  <= jtag_addr_d;
            mon_q        <= mon_d;
            mready_q     <= mready_d;
            overrun_q    <= overrun_d;
            av_wait_q    <= av_wait_d;
            ram_en_q     <= ram_en_d;
            ram_we_q     <= ram_we_d;
            ram_addr_q   <= ram_addr_d;
            ram_wdata_q  <= ram_wdata_d;
            ram_be_q     <= ram_be_d;
            gnt_src_q    <= gnt_src_d;
        end
    end

    assign av_waitrequest = av_wait_q;
    assign av_readdata    = ram_rdata;
    assign MonDReg        = mon_q;
    assign monitor_ready  = mready_q;
    assign jtag_overrun   = overrun_q;
    assign ram_en         = ram_en_q;
    assign ram_we         = ram_we_q;
    assign ram_addr       = ram_addr_q;
    assign ram_wdata      = ram_wdata_q;
    assign ram_be         = ram_be_q;

endmodule

// File: tb/tb_systemfile_cpu_cpu_debug_mem_arbiter.sv
// Directed bench for the debug RAM arbiter, with a behavioural 256x32 RAM attached.
module tb_systemfile_cpu_cpu_debug_mem_arbiter;

    logic        clk;
    logic        reset;
    logic [7:0]  av_address;
    logic        av_read;
    logic        av_write;
    logic [31:0] av_writedata;
    logic [3:0]  av_byteenable;
    logic        av_waitrequest;
    logic [31:0] av_readdata;
    logic        jtag_addr_load;
    logic [7:0]  jtag_addr_in;
    logic        jtag_req;
    logic        jtag_wr;
    logic [31:0] jtag_wdata;
    logic        jtag_clr_err;
    logic [31:0] MonDReg;
    logic        monitor_ready;
    logic        jtag_overrun;
    logic        ram_en;
    logic        ram_we;
    logic [7:0]  ram_addr;
    logic [31:0] ram_wdata;
    logic [3:0]  ram_be;
    logic [31:0] ram_rdata;

    int errors = 0;
    int checks = 0;

    logic [31:0] mem [256];
    logic        loaded = 1'b0;

    systemfile_cpu_cpu_debug_mem_arbiter dut (
        .clk            (clk),
        .reset          (reset),
        .av_address     (av_address),
        .av_read        (av_read),
        .av_write       (av_write),
        .av_writedata   (av_writedata),
        .av_byteenable  (av_byteenable),
        .av_waitrequest (av_waitrequest),
        .av_readdata    (av_readdata),
        .jtag_addr_load (jtag_addr_load),
        .jtag_addr_in   (jtag_addr_in),
        .jtag_req       (jtag_req),
        .jtag_wr        (jtag_wr),
        .jtag_wdata     (jtag_wdata),
        .jtag_clr_err   (jtag_clr_err),
        .MonDReg        (MonDReg),
        .monitor_ready  (monitor_ready),
        .jtag_overrun   (jtag_overrun),
        .ram_en         (ram_en),
        .ram_we         (ram_we),
        .ram_addr       (ram_addr),
        .ram_wdata      (ram_wdata),
        .ram_be         (ram_be),
        .ram_rdata      (ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM fixture: preloaded with A500_00xx, byte-enabled writes, 1-cycle read latency.
    always @(posedge clk) begin
        if (!loaded) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'hA500_0000 | 32'(i);
            loaded    <= 1'b1;
            ram_rdata <= '0;
        end else if (ram_en) begin
            if (ram_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (ram_be[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
                end
            end else begin
                ram_rdata <= mem[ram_addr];
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Pulse one JTAG request, then follow it for a bounded number of cycles.
    task automatic jtag_access(input logic wr, input logic [31:0] wd, output int n_en,
                               output logic [7:0] addr, output logic we, output logic done);
        jtag_req = 1'b1; jtag_wr = wr; jtag_wdata = wd;
        tick();
        jtag_req = 1'b0;
        n_en = 0; addr = '0; we = 1'b0; done = 1'b0;
        for (int i = 0; i < 10 && !done; i++) begin
            tick();
            if (ram_en) begin n_en++; addr = ram_addr; we = ram_we; end
            if (monitor_ready) done = 1'b1;
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (av_waitrequest !== 1'b1) begin errors++; $display("FAIL rst_wait got=%b exp=1", av_waitrequest); end
        checks++; if (ram_en !== 1'b0 || ram_we !== 1'b0) begin errors++; $display("FAIL rst_ram got en=%b we=%b exp 0/0", ram_en, ram_we); end
        checks++; if (monitor_ready !== 1'b1) begin errors++; $display("FAIL rst_mready got=%b exp=1", monitor_ready); end
        checks++; if (MonDReg !== 32'h0) begin errors++; $display("FAIL rst_mondreg got=%h exp=0", MonDReg); end
        checks++; if (jtag_overrun !== 1'b0) begin errors++; $display("FAIL rst_overrun got=%b exp=0", jtag_overrun); end
    endtask

    task automatic test_avalon_wr_rd();
        av_write = 1'b1; av_address = 8'h10; av_writedata = 32'hDEADBEEF; av_byteenable = 4'hF;
        tick();
        checks++; if (ram_en !== 1'b1 || ram_we !== 1'b1 || ram_addr !== 8'h10) begin errors++; $display("FAIL av_wr_strobe got en=%b we=%b addr=%h exp 1/1/10", ram_en, ram_we, ram_addr); end
        checks++; if (ram_wdata !== 32'hDEADBEEF || ram_be !== 4'hF) begin errors++; $display("FAIL av_wr_data got %h be=%h exp deadbeef be=f", ram_wdata, ram_be); end
        checks++; if (av_waitrequest !== 1'b0) begin errors++; $display("FAIL av_wr_wait got=%b exp=0", av_waitrequest); end
        av_write = 1'b0;
        tick();
        checks++; if (av_waitrequest !== 1'b1 || ram_en !== 1'b0) begin errors++; $display("FAIL av_wr_after got wait=%b en=%b exp 1/0", av_waitrequest, ram_en); end
        av_read = 1'b1;
        tick();
        checks++; if (ram_en !== 1'b1 || ram_we !== 1'b0 || av_waitrequest !== 1'b1) begin errors++; $display("FAIL av_rd_access got en=%b we=%b wait=%b exp 1/0/1", ram_en, ram_we, av_waitrequest); end
        tick();
        checks++; if (av_waitrequest !== 1'b0 || av_readdata !== 32'hDEADBEEF) begin errors++; $display("FAIL av_rd_data got wait=%b data=%h exp 0/deadbeef", av_waitrequest, av_readdata); end
        av_read = 1'b0;
        tick();
        checks++; if (av_waitrequest !== 1'b1) begin errors++; $display("FAIL av_rd_after got=%b exp=1", av_waitrequest); end
    endtask

    task automatic test_jtag_wrap();
        int n; logic [7:0] a; logic w; logic d;
        logic [7:0]  exp_a [3];
        logic [31:0] wd [3];
        exp_a[0] = 8'hFE; exp_a[1] = 8'hFF; exp_a[2] = 8'h00;
        wd[0] = 32'h11; wd[1] = 32'h22; wd[2] = 32'h33;
        jtag_addr_load = 1'b1; jtag_addr_in = 8'hFE;
        tick();
        jtag_addr_load = 1'b0;
        for (int i = 0; i < 3; i++) begin
            jtag_access(1'b1, wd[i], n, a, w, d);
            checks++; if (d !== 1'b1 || n != 1 || a !== exp_a[i] || w !== 1'b1) begin errors++; $display("FAIL jtag_wr%0d got done=%b n=%0d addr=%h we=%b exp 1/1/%h/1", i, d, n, a, w, exp_a[i]); end
        end
        jtag_addr_load = 1'b1; jtag_addr_in = 8'hFF;
        tick();
        jtag_addr_load = 1'b0;
        jtag_access(1'b0, 32'h0, n, a, w, d);
        checks++; if (d !== 1'b1 || a !== 8'hFF || w !== 1'b0) begin errors++; $display("FAIL jtag_rd_ff got done=%b addr=%h we=%b exp 1/ff/0", d, a, w); end
        checks++; if (MonDReg !== 32'h22) begin errors++; $display("FAIL jtag_mondreg got=%h exp=00000022", MonDReg); end
    endtask

    task automatic test_round_robin();
        int n; logic [7:0] a; logic w; logic d;
        do_reset();
        jtag_addr_load = 1'b1; jtag_addr_in = 8'h20; jtag_req = 1'b1; jtag_wr = 1'b0;
        tick();
        jtag_addr_load = 1'b0; jtag_req = 1'b0;
        av_read = 1'b1; av_address = 8'h10;
        tick();
        checks++; if (ram_en !== 1'b1 || ram_addr !== 8'h20) begin errors++; $display("FAIL rr_tie1_jtag got en=%b addr=%h exp 1/20", ram_en, ram_addr); end
        tick();
        checks++; if (av_waitrequest !== 1'b1) begin errors++; $display("FAIL rr_av_waits got=%b exp=1", av_waitrequest); end
        tick();
        checks++; if (monitor_ready !== 1'b1 || MonDReg !== 32'hA5000020) begin errors++; $display("FAIL rr_jtag_data got rdy=%b mon=%h exp 1/a5000020", monitor_ready, MonDReg); end
        tick();
        checks++; if (ram_en !== 1'b1 || ram_addr !== 8'h10) begin errors++; $display("FAIL rr_av_next got en=%b addr=%h exp 1/10", ram_en, ram_addr); end
        tick();
        checks++; if (av_waitrequest !== 1'b0 || av_readdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rr_av_data got wait=%b data=%h exp 0/deadbeef", av_waitrequest, av_readdata); end
        av_read = 1'b0;
        tick();
        // JTAG-only access leaves last grant on JTAG, so the next tie goes to Avalon.
        jtag_access(1'b0, 32'h0, n, a, w, d);
        checks++; if (d !== 1'b1 || a !== 8'h21) begin errors++; $display("FAIL rr_jtag_solo got done=%b addr=%h exp 1/21", d, a); end
        jtag_req = 1'b1; jtag_wr = 1'b0;
        tick();
        jtag_req = 1'b0;
        av_read = 1'b1; av_address = 8'h10;
        tick();
        checks++; if (ram_en !== 1'b1 || ram_addr !== 8'h10) begin errors++; $display("FAIL rr_tie2_av got en=%b addr=%h exp 1/10", ram_en, ram_addr); end
        tick();
        checks++; if (av_waitrequest !== 1'b0) begin errors++; $display("FAIL rr_tie2_wait got=%b exp=0", av_waitrequest); end
        av_read = 1'b0;
        tick();
        tick();
        checks++; if (ram_en !== 1'b1 || ram_addr !== 8'h22 || ram_we !== 1'b0) begin errors++; $display("FAIL rr_tie2_jtag got en=%b addr=%h we=%b exp 1/22/0", ram_en, ram_addr, ram_we); end
        tick();
        tick();
        checks++; if (monitor_ready !== 1'b1 || MonDReg !== 32'hA5000022) begin errors++; $display("FAIL rr_tie2_data got rdy=%b mon=%h exp 1/a5000022", monitor_ready, MonDReg); end
    endtask

    task automatic test_overrun();
        int n_en;
        jtag_req = 1'b1; jtag_wr = 1'b0;
        tick();
        checks++; if (monitor_ready !== 1'b0) begin errors++; $display("FAIL ovr_mready_low got=%b exp=0", monitor_ready); end
        tick();
        jtag_req = 1'b0;
        n_en = ram_en ? 1 : 0;
        for (int i = 0; i < 5; i++) begin tick(); if (ram_en) n_en++; end
        checks++; if (n_en != 1) begin errors++; $display("FAIL ovr_one_access got=%0d exp=1", n_en); end
        checks++; if (jtag_overrun !== 1'b1 || monitor_ready !== 1'b1) begin errors++; $display("FAIL ovr_flag got ovr=%b rdy=%b exp 1/1", jtag_overrun, monitor_ready); end
        jtag_clr_err = 1'b1;
        tick();
        jtag_clr_err = 1'b0;
        checks++; if (jtag_overrun !== 1'b0) begin errors++; $display("FAIL ovr_clear got=%b exp=0", jtag_overrun); end
        jtag_req = 1'b1;
        tick();
        jtag_clr_err = 1'b1;
        tick();
        jtag_req = 1'b0; jtag_clr_err = 1'b0;
        checks++; if (jtag_overrun !== 1'b1) begin errors++; $display("FAIL ovr_set_beats_clr got=%b exp=1", jtag_overrun); end
        for (int i = 0; i < 3; i++) tick();
        jtag_clr_err = 1'b1;
        tick();
        jtag_clr_err = 1'b0;
        checks++; if (jtag_overrun !== 1'b0 || monitor_ready !== 1'b1) begin errors++; $display("FAIL ovr_clear2 got ovr=%b rdy=%b exp 0/1", jtag_overrun, monitor_ready); end
    endtask

    task automatic test_load_on_completion();
        int n; logic [7:0] a; logic w; logic d;
        jtag_addr_load = 1'b1; jtag_addr_in = 8'h30;
        tick();
        jtag_addr_load = 1'b0;
        jtag_req = 1'b1; jtag_wr = 1'b1; jtag_wdata = 32'h55;
        tick();
        jtag_req = 1'b0;
        tick();
        checks++; if (ram_en !== 1'b1 || ram_we !== 1'b1 || ram_addr !== 8'h30 || ram_be !== 4'hF) begin errors++; $display("FAIL ld_wr got en=%b we=%b addr=%h be=%h exp 1/1/30/f", ram_en, ram_we, ram_addr, ram_be); end
        jtag_addr_load = 1'b1; jtag_addr_in = 8'h40;
        tick();
        jtag_addr_load = 1'b0;
        checks++; if (monitor_ready !== 1'b1) begin errors++; $display("FAIL ld_done got=%b exp=1", monitor_ready); end
        jtag_access(1'b0, 32'h0, n, a, w, d);
        checks++; if (d !== 1'b1 || a !== 8'h40) begin errors++; $display("FAIL ld_wins got done=%b addr=%h exp 1/40", d, a); end
        checks++; if (MonDReg !== 32'hA5000040) begin errors++; $display("FAIL ld_rd_data got=%h exp=a5000040", MonDReg); end
    endtask

    task automatic test_reset_mid_access();
        int n_en;
        jtag_req = 1'b1; jtag_wr = 1'b0;
        tick();
        jtag_req = 1'b0;
        tick();
        checks++; if (ram_en !== 1'b1 || ram_we !== 1'b0) begin errors++; $display("FAIL rm_access got en=%b we=%b exp 1/0", ram_en, ram_we); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if (ram_en !== 1'b0 || av_waitrequest !== 1'b1) begin errors++; $display("FAIL rm_abort got en=%b wait=%b exp 0/1", ram_en, av_waitrequest); end
        checks++; if (monitor_ready !== 1'b1 || MonDReg !== 32'h0) begin errors++; $display("FAIL rm_jtag got rdy=%b mon=%h exp 1/0", monitor_ready, MonDReg); end
        n_en = 0;
        for (int i = 0; i < 4; i++) begin tick(); if (ram_en) n_en++; end
        checks++; if (n_en != 0) begin errors++; $display("FAIL rm_discard got=%0d exp=0", n_en); end
        av_write = 1'b1; av_address = 8'h50; av_writedata = 32'h12345678; av_byteenable = 4'b0011;
        tick();
        checks++; if (ram_en !== 1'b1 || av_waitrequest !== 1'b0 || ram_be !== 4'b0011) begin errors++; $display("FAIL rm_idle_wr got en=%b wait=%b be=%b exp 1/0/0011", ram_en, av_waitrequest, ram_be); end
        av_write = 1'b0;
        tick();
        av_read = 1'b1;
        tick();
        tick();
        checks++; if (av_waitrequest !== 1'b0 || av_readdata !== 32'hA5005678) begin errors++; $display("FAIL rm_be_read got wait=%b data=%h exp 0/a5005678", av_waitrequest, av_readdata); end
        av_read = 1'b0;
        tick();
    endtask

    initial begin
        reset = 1'b1;
        av_address = '0; av_read = 1'b0; av_write = 1'b0; av_writedata = '0; av_byteenable = '0;
        jtag_addr_load = 1'b0; jtag_addr_in = '0; jtag_req = 1'b0; jtag_wr = 1'b0;
        jtag_wdata = '0; jtag_clr_err = 1'b0;
        test_reset();
        test_avalon_wr_rd();
        test_jtag_wrap();
        test_round_robin();
        test_overrun();
        test_load_on_completion();
        test_reset_mid_access();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
